// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size encodings, lane width.
// Also holds the alignment rule used when sub-word access (LSU_SUBWORD_EN) is enabled.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int LANE_W = 8;

  // Size 2'b11 is handled like a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts (and optionally sign-extends) a load lane,
// and merges sub-word store data into a captured memory word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [15:0] shifted;

  always_comb begin
    shifted  = 16'(word_i >> {lane_i, 3'b000});
    rdata_o  = word_i;
    merged_o = wdata_i;
    case (size_i)
      SIZE_B: begin
        rdata_o  = {{(32-LANE_W){signed_i & shifted[LANE_W-1]}}, shifted[LANE_W-1:0]};
        merged_o = word_i;
        merged_o[{lane_i, 3'b000} +: LANE_W] = wdata_i[LANE_W-1:0];
      end
      SIZE_H: begin
        rdata_o  = {{(32-2*LANE_W){signed_i & shifted[2*LANE_W-1]}}, shifted};
        merged_o = word_i;
        // Halfword lanes are aligned, so only addr[1] selects the half.
        merged_o[{lane_i[1], 4'b0000} +: 2*LANE_W] = wdata_i[2*LANE_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator for a word memory (sync write, comb read).
// Define LSU_SUBWORD_EN for byte/half access with read-modify-write; otherwise word-only.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic        mem_writeEnable,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        misaligned;
  logic        needs_read;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

`ifdef LSU_SUBWORD_EN
  assign misaligned = is_misaligned(req_size, req_addr[1:0]);
  // Sub-word stores need the old word first; loads always read.
  assign needs_read = ~req_write | ((req_size != SIZE_W) & (req_size != 2'b11));

  lsu_lane u_lane (
    .word_i   (mem_dataOut),
    .wdata_i  (wdata_q),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_o  (load_data),
    .merged_o (merged_word)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = ^{size_q, signed_q, lane_q};
  assign misaligned  = (req_addr[1:0] != 2'b00);
  assign needs_read  = ~req_write;
  assign load_data   = mem_dataOut;
  assign merged_word = wdata_q;
`endif

  // Ready is forced low while reset is held, even though the state already reads IDLE.
  assign req_ready       = (state_q == IDLE) & ~reset;
  assign accept          = req_valid & req_ready;
  assign mem_writeEnable = (state_q == WRITE);
  assign mem_address     = mem_address_q;
  assign mem_dataIn      = mem_data_in_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_error       = rsp_error_q;
  assign rsp_rdata       = rsp_rdata_q;

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    signed_d      = signed_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_data_in_d = mem_data_in_q;
    rsp_valid_d   = 1'b0;
    rsp_error_d   = 1'b0;
    rsp_rdata_d   = 32'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          lane_d   = req_addr[1:0];
          wdata_d  = req_wdata;
          if (misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            mem_address_d = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
            if (needs_read) begin
              state_d = READ;
            end else begin
              state_d       = WRITE;
              mem_data_in_d = req_wdata;
            end
          end
        end
      end
      READ: begin
        if (write_q) begin
          state_d       = WRITE;
          mem_data_in_d = merged_word;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      size_q        <= SIZE_W;
      signed_q      <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 32'd0;
      mem_address_q <= 32'd0;
      mem_data_in_q <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_error_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_error_q   <= rsp_error_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed steps plus random traffic against
// a byte-level reference memory; follows LSU_SUBWORD_EN to pick the expected behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_vectors = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_writeEnable) mem[mem_address[9:0]] <= mem_dataIn;
  assign mem_dataOut = mem[mem_address[9:0]];

  load_store_unit #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    assert (obs === exp) else begin
      n_miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access width in bytes as seen by the reference model.
  function automatic int nbytes_of(input logic [1:0] size);
`ifdef LSU_SUBWORD_EN
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`else
    return 4;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    int nb = nbytes_of(size);
    int sh = int'(addr[1:0]);
    logic [31:0] v, mask;
    v = ref_mem[addr[11:2]] >> (8 * sh);
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      v = v & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    int nb = nbytes_of(size);
    int sh = int'(addr[1:0]);
    logic [31:0] w;
    w = ref_mem[addr[11:2]];
    for (int b = 0; b < nb; b++) w[8*(sh+b) +: 8] = wdata[8*b +: 8];
    return w;
  endfunction

  task automatic do_req(input logic w, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    int nb, exp_lat, lat, we_cnt;
    bit err, got, ready_bad;
    logic [31:0] exp_rd, new_word, we_addr, we_data, rd;
    logic er;
    nb = nbytes_of(size);
    err = (int'(addr[1:0]) % nb) != 0;
    exp_rd = 32'd0;
    new_word = ref_mem[addr[11:2]];
    if (!err && !w) exp_rd = model_load(addr, size, sgn);
    if (!err && w) new_word = model_store(addr, size, wdata);
    exp_lat = err ? 1 : (w && nb < 4) ? 3 : 2;

    @(negedge clk);
    check("rsp_idle", {31'd0, rsp_valid}, 32'd0);
    req_write = w; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;

    got = 0; lat = 0; we_cnt = 0; ready_bad = 0; rd = 32'd0; er = 1'b0;
    we_addr = 32'd0; we_data = 32'd0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (req_ready) ready_bad = 1;
      if (mem_writeEnable) begin we_cnt++; we_addr = mem_address; we_data = mem_dataIn; end
      if (rsp_valid) begin got = 1; lat = n; rd = rsp_rdata; er = rsp_error; end
    end
    check("rsp_latency", lat, exp_lat);
    check("ready_busy", {31'd0, ready_bad}, 32'd0);
    check("rsp_error", {31'd0, er}, {31'd0, err});
    check("rsp_rdata", rd, exp_rd);
    check("we_cycles", we_cnt, (w && !err) ? 1 : 0);
    if (we_cnt > 0) begin
      check("we_addr", we_addr, {22'd0, addr[11:2]});
      check("we_data", we_data, new_word);
    end
    if (w && !err) ref_mem[addr[11:2]] = new_word;
    $display("txn %s size=%0d sgn=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
             w ? "ST" : "LD", size, sgn, addr, wdata, lat, er, rd);
  endtask

  initial begin
    logic [31:0] addr, old_word;
    int idx;

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_we", {31'd0, mem_writeEnable}, 32'd0);
    check("reset_mem_address", mem_address, 32'd0);
    check("reset_mem_dataIn", mem_dataIn, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Fill the 16-word working region through the DUT.
    for (int i = 0; i < 16; i++) do_req(1'b1, 2'b10, 1'b0, i * 4, $urandom, 0);

    // Directed cases.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 0);
    check("word_readback", ref_mem[4], 32'hDEADBEEF);
`ifdef LSU_SUBWORD_EN
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, 0);
    check("byte_merge_model", ref_mem[4], 32'hDEAD55EF);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 0);
    do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'd0, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h1234, 0);
`endif
    do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h11, 32'hCAFEF00D, 0);

    // Random traffic with junk in the undecoded upper address bits.
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, 15);
      addr = ($urandom & 32'hFFFFF000) | (idx << 2) | $urandom_range(0, 3);
      do_req(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             addr, $urandom, 0);
    end

    // req_valid held across RESP: the repeat is accepted at the first IDLE edge.
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 0);

    // Reset in the middle of a word store's WRITE cycle.
    old_word = ref_mem[5];
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'h14; req_wdata = ~old_word; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("write_started", {31'd0, mem_writeEnable}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_drops_we", {31'd0, mem_writeEnable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_midreset", {31'd0, req_ready}, 32'd1);
    check("mem_unchanged", mem[5], old_word);
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
